// File: rtl/mips_mem_responder_pkg.sv
// Shared constants for the mips memory responder: FSM encoding, data width
// and the address of the memory-mapped output register.
package mips_mem_responder_pkg;

  localparam int MIPS_WIDTH = 8;
  localparam logic [7:0] IO_ADR_DEFAULT = 8'hFF;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

endpackage

// File: rtl/mips_mem_responder_byte_ram.sv
// 2^WIDTH x WIDTH byte RAM: one synchronous write port, one asynchronous read
// port. Contents are not reset.
module byte_ram
  import mips_mem_responder_pkg::*;
#(
  parameter int WIDTH = MIPS_WIDTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle mips core: boot loader that fills
// RAM, core read/write service, and one memory-mapped output register.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int               WIDTH  = MIPS_WIDTH,
  parameter logic [WIDTH-1:0] IO_ADR = IO_ADR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_rst,
  output logic [WIDTH-1:0] out_data,
  output logic             out_strobe
);

  localparam logic [WIDTH-1:0] LAST_LD_ADR = IO_ADR - 1'b1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ld_ptr_q, ld_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_strobe_q, out_strobe_d;

  logic             ld_accept;
  logic             io_write;
  logic             ram_we;
  logic [WIDTH-1:0] ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  // memdata does not depend on memread; the core ignores it while memread is low.
  logic unused_memread;
  assign unused_memread = memread;

  assign ld_ready  = rst && (state_q == ST_LOAD);
  assign ld_accept = ld_valid && ld_ready;
  assign io_write  = (state_q == ST_RUN) && memwrite && (adr == IO_ADR);
  assign cpu_rst   = (state_q == ST_RUN);

  always_comb begin
    state_d      = state_q;
    ld_ptr_d     = ld_ptr_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (ld_accept) begin
          ld_ptr_d = ld_ptr_q + 1'b1;
          // Stop before the I/O slot so the image can never shadow or wrap.
          if (ld_last || (ld_ptr_q == LAST_LD_ADR)) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN: begin
        if (io_write) begin
          out_data_d   = writedata;
          out_strobe_d = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_LOAD;
      ld_ptr_q     <= '0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_ptr_q     <= ld_ptr_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
    end
  end

  // The single RAM write port belongs to the loader in LOAD and the core in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = adr;
    ram_wdata = writedata;
    if (state_q == ST_LOAD) begin
      ram_we    = ld_accept;
      ram_waddr = ld_ptr_q;
      ram_wdata = ld_data;
    end else if (state_q == ST_RUN) begin
      ram_we = memwrite && (adr != IO_ADR);
    end
  end

  byte_ram #(
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (adr),
    .rdata (ram_rdata)
  );

  always_comb begin
    memdata = '0;
    if (state_q == ST_RUN) begin
      memdata = (adr == IO_ADR) ? out_data_q : ram_rdata;
    end
  end

  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: behavioural model with a per-cycle
// compare process, plus hand-computed literal checks.
module tb_mips_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       memread = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] writedata = 8'h00;
  logic [7:0] memdata;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_last = 1'b0;
  logic       ld_ready;
  logic       cpu_rst;
  logic [7:0] out_data;
  logic       out_strobe;

  int vectors = 0;
  int miscompares = 0;

  mips_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .memread    (memread),
    .memwrite   (memwrite),
    .adr        (adr),
    .writedata  (writedata),
    .memdata    (memdata),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .cpu_rst    (cpu_rst),
    .out_data   (out_data),
    .out_strobe (out_strobe)
  );

  always #5 clk = ~clk;

  typedef enum {M_LOAD, M_RELEASE, M_RUN} phase_t;
  phase_t     m_phase = M_LOAD;
  int         m_ptr = 0;
  logic [7:0] m_out = 8'h00;
  logic       m_strobe = 1'b0;
  logic [7:0] m_ram [256];
  bit         m_known [256];
  int         strobe_seen = 0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: what memory and the boot sequence should look like.
  always @(posedge clk) begin
    if (!rst) begin
      m_phase  <= M_LOAD;
      m_ptr    <= 0;
      m_out    <= 8'h00;
      m_strobe <= 1'b0;
    end else begin
      m_strobe <= 1'b0;
      case (m_phase)
        M_LOAD: begin
          if (ld_valid) begin
            m_ram[m_ptr]   <= ld_data;
            m_known[m_ptr] <= 1'b1;
            m_ptr          <= m_ptr + 1;
            if (ld_last || m_ptr == 254) m_phase <= M_RELEASE;
          end
        end
        M_RELEASE: m_phase <= M_RUN;
        default: begin
          if (memwrite) begin
            if (adr == 8'hFF) begin
              m_out    <= writedata;
              m_strobe <= 1'b1;
            end else begin
              m_ram[adr]   <= writedata;
              m_known[adr] <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    checkOutput("ld_ready", {7'd0, ld_ready}, {7'd0, rst && m_phase == M_LOAD});
    checkOutput("cpu_rst", {7'd0, cpu_rst}, {7'd0, m_phase == M_RUN});
    checkOutput("out_data", out_data, m_out);
    checkOutput("out_strobe", {7'd0, out_strobe}, {7'd0, m_strobe});
    if (m_phase != M_RUN) checkOutput("memdata_idle", memdata, 8'h00);
    else if (adr == 8'hFF) checkOutput("memdata_io", memdata, m_out);
    else if (m_known[adr]) checkOutput("memdata_ram", memdata, m_ram[adr]);
    if (out_strobe === 1'b1) strobe_seen++;
  end

  task automatic applyStimulus();
    logic [7:0] img [4];
    img[0] = 8'h80; img[1] = 8'h22; img[2] = 8'h10; img[3] = 8'h05;

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_ld_ready", {7'd0, ld_ready}, 8'h00);
    checkOutput("rst_cpu_rst", {7'd0, cpu_rst}, 8'h00);
    checkOutput("rst_out_data", out_data, 8'h00);
    rst = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("post_rst_ld_ready", {7'd0, ld_ready}, 8'h01);

    // 4-byte image terminated by ld_last
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = img[i]; ld_last = (i == 3);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'hCC;
    @(negedge clk);
    checkOutput("boot4_ld_ready_drop", {7'd0, ld_ready}, 8'h00);
    checkOutput("boot4_release_cpu_rst", {7'd0, cpu_rst}, 8'h00);
    tick();
    @(negedge clk);
    checkOutput("boot4_cpu_rst_rise", {7'd0, cpu_rst}, 8'h01);
    memread = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adr = 8'(i);
      @(negedge clk);
      checkOutput("boot4_readback", memdata, img[i]);
    end

    // RAM write, then simultaneous read/write
    tick();
    memwrite = 1'b1; adr = 8'h40; writedata = 8'hA5;
    tick();
    memwrite = 1'b0;
    @(negedge clk);
    checkOutput("wr40_read", memdata, 8'hA5);
    tick();
    memwrite = 1'b1; writedata = 8'h3C;
    @(negedge clk);
    checkOutput("rw40_prewrite", memdata, 8'hA5);
    tick();
    memwrite = 1'b0;
    @(negedge clk);
    checkOutput("rw40_postwrite", memdata, 8'h3C);

    // Output register write and strobes
    tick();
    memwrite = 1'b1; adr = 8'hFF; writedata = 8'h07;
    tick();
    memwrite = 1'b0;
    @(negedge clk);
    checkOutput("io_strobe_on", {7'd0, out_strobe}, 8'h01);
    checkOutput("io_out_data", out_data, 8'h07);
    checkOutput("io_readback", memdata, 8'h07);
    tick();
    @(negedge clk);
    checkOutput("io_strobe_off", {7'd0, out_strobe}, 8'h00);
    strobe_seen = 0;
    memwrite = 1'b1; writedata = 8'h11;
    tick();
    writedata = 8'h22;
    tick();
    memwrite = 1'b0;
    repeat (3) tick();
    checkOutput("io_b2b_strobes", 8'(strobe_seen), 8'h02);
    checkOutput("io_b2b_data", out_data, 8'h22);

    // Reset mid-load, then a shorter reload
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 8'h31 + 8'(i); ld_last = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("midload_rst_cpu_rst", {7'd0, cpu_rst}, 8'h00);
    checkOutput("midload_rst_out_data", out_data, 8'h00);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 8'h41 + 8'(i); ld_last = (i == 1);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    repeat (2) tick();
    adr = 8'h00; @(negedge clk); checkOutput("reload_b0", memdata, 8'h41);
    adr = 8'h01; @(negedge clk); checkOutput("reload_b1", memdata, 8'h42);
    adr = 8'h02; @(negedge clk); checkOutput("reload_b2_kept", memdata, 8'h33);

    // Full image without ld_last; core write during load is ignored
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 255; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i) ^ 8'h5A; ld_last = 1'b0;
      memwrite = (i == 20); adr = 8'h10; writedata = 8'hEE;
      tick();
    end
    memwrite = 1'b0;
    ld_data = 8'h99;
    @(negedge clk);
    checkOutput("full_ld_ready_drop", {7'd0, ld_ready}, 8'h00);
    tick();
    ld_valid = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("full_cpu_rst", {7'd0, cpu_rst}, 8'h01);
    adr = 8'h10; @(negedge clk); checkOutput("full_b10_loader", memdata, 8'h4A);
    adr = 8'hFE; @(negedge clk); checkOutput("full_bFE", memdata, 8'hA4);
    adr = 8'h00; @(negedge clk); checkOutput("full_b00_nowrap", memdata, 8'h5A);
    adr = 8'hFF; @(negedge clk); checkOutput("full_io_clear", memdata, 8'h00);
    tick();
  endtask

  initial begin
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
